// File: rtl/dmem_ctrl.sv
// dmem_ctrl: word-addressed data RAM with a fixed access latency.
// Raises Stall while an access is in flight; commits on the edge into DONE.
// Optional macro DMEM_ALIGN_CHECK_EN rejects misaligned requests and sets a
// sticky Fault flag; without it Fault stays 0 and addr[1:0] is ignored.
module dmem_ctrl #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WAIT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemEn,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        Fault
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          we_q, we_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          fault_q, fault_d;

    logic [31:0]   mem [DEPTH];

    logic          misal;
    logic          accept;
    logic          commit;
    logic [AW-1:0] c_idx;
    logic [31:0]   c_data;
    logic          c_we;
    logic          unused_addr;

`ifdef DMEM_ALIGN_CHECK_EN
    assign misal = (ALUResult[1:0] != 2'b00);
`else
    assign misal = 1'b0;
`endif

    assign accept      = MemEn & ~misal;
    assign unused_addr = ^{ALUResult[31:AW+2], ALUResult[1:0]};

    // Next-state, capture, commit selection and Stall generation.
    // With WAIT = 0 the commit happens on the capture edge, so the live
    // inputs stand in for the (not yet loaded) captured copies.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        Stall   = 1'b0;
        commit  = 1'b0;
        c_idx   = idx_q;
        c_data  = wdata_q;
        c_we    = we_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    Stall   = 1'b1;
                    idx_d   = ALUResult[AW+1:2];
                    wdata_d = WriteData;
                    we_d    = MemWrite;
                    if (WAIT == 0) begin
                        state_d = DONE;
                        commit  = 1'b1;
                        c_idx   = ALUResult[AW+1:2];
                        c_data  = WriteData;
                        c_we    = MemWrite;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = WAIT[3:0];
                    end
                end else if (MemEn && misal) begin
                    fault_d = 1'b1;
                end
            end
            BUSY: begin
                Stall = 1'b1;
                if (!MemEn) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd1) begin
                    state_d = DONE;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (commit && !c_we) begin
            rdata_d = mem[c_idx];
        end
    end

    // Control and data registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    // RAM write port; gated by reset so an interrupted access never writes.
    always_ff @(posedge clk) begin
        if (reset && commit && c_we) begin
            mem[c_idx] <= c_data;
        end
    end

    assign ReadData = rdata_q;
    assign Fault    = fault_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: two instances (WAIT = 2 and WAIT = 0),
// directed scenarios followed by randomized accesses against an array model.
module tb_dmem_ctrl;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned W0    = 2;
    localparam int unsigned W1    = 0;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        en   [2];
    logic        wr   [2];
    logic [31:0] addr [2];
    logic [31:0] wd   [2];
    logic [31:0] rd   [2];
    logic        stall[2];
    logic        fault[2];

    logic [31:0] mem_m  [2][DEPTH];
    logic [31:0] rd_m   [2];
    logic        fault_m[2];

    int unsigned n_checks;
    int unsigned n_err;

    dmem_ctrl #(.DEPTH(DEPTH), .WAIT(W0)) u_dut0 (
        .clk(clk), .reset(reset), .MemEn(en[0]), .MemWrite(wr[0]),
        .ALUResult(addr[0]), .WriteData(wd[0]), .ReadData(rd[0]),
        .Stall(stall[0]), .Fault(fault[0])
    );

    dmem_ctrl #(.DEPTH(DEPTH), .WAIT(W1)) u_dut1 (
        .clk(clk), .reset(reset), .MemEn(en[1]), .MemWrite(wr[1]),
        .ALUResult(addr[1]), .WriteData(wd[1]), .ReadData(rd[1]),
        .Stall(stall[1]), .Fault(fault[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int unsigned wait_of(input int inst);
        return (inst == 0) ? W0 : W1;
    endfunction

    function automatic int unsigned widx(input logic [31:0] a);
        return (a >> 2) % DEPTH;
    endfunction

    task automatic drive(input int inst, input logic e, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        en[0]     = 1'b0;
        en[1]     = 1'b0;
        en[inst]  = e;
        wr[inst]  = w;
        addr[inst] = a;
        wd[inst]  = d;
    endtask

    // Counts stall cycles up to the DONE cycle and checks the outcome.
    task automatic finish_normal(input int inst, input logic w,
                                 input logic [31:0] a, input logic [31:0] d);
        int unsigned cnt;
        bit          done;
        cnt  = 0;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (stall[inst]) cnt++;
            else done = 1'b1;
        end
        check("done_reached", 32'(done), 32'd1);
        check("stall_cycles", cnt, wait_of(inst) + 1);
        if (w) mem_m[inst][widx(a)] = d;
        else   rd_m[inst] = mem_m[inst][widx(a)];
        check(w ? "rdata_hold" : "rdata_load", rd[inst], rd_m[inst]);
        check("fault_done", 32'(fault[inst]), 32'(fault_m[inst]));
        @(posedge clk); #1;
    endtask

    task automatic do_access(input int inst, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input bit abort);
        drive(inst, 1'b1, w, a, d);
        if (ALIGN && a[1:0] != 2'b00) begin
            @(negedge clk);
            check("misal_stall", 32'(stall[inst]), 32'd0);
            @(posedge clk); #1;
            drive(inst, 1'b0, w, a, d);
            fault_m[inst] = 1'b1;
            @(negedge clk);
            check("misal_fault", 32'(fault[inst]), 32'd1);
            check("misal_rdata", rd[inst], rd_m[inst]);
            check("misal_idle", 32'(stall[inst]), 32'd0);
            @(posedge clk); #1;
        end else if (abort && wait_of(inst) > 0) begin
            @(negedge clk);
            check("abort_req_stall", 32'(stall[inst]), 32'd1);
            @(posedge clk); #1;
            drive(inst, 1'b0, w, a, d);
            @(negedge clk);
            check("abort_busy_stall", 32'(stall[inst]), 32'd1);
            @(posedge clk); #1;
            @(negedge clk);
            check("abort_idle", 32'(stall[inst]), 32'd0);
            check("abort_rdata", rd[inst], rd_m[inst]);
            @(posedge clk); #1;
        end else begin
            finish_normal(inst, w, a, d);
        end
    endtask

    task automatic idle(input int unsigned n);
        en[0] = 1'b0;
        en[1] = 1'b0;
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                check("idle_stall", 32'(stall[k]), 32'd0);
                check("idle_rdata", rd[k], rd_m[k]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic reset_mid(input logic [31:0] d);
        drive(0, 1'b1, 1'b1, 32'h30, d);
        @(posedge clk); #1;
        reset = 1'b0;
        en[0] = 1'b0;
        en[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rd_m[k]    = '0;
            fault_m[k] = 1'b0;
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_rdata", rd[k], 32'd0);
            check("rst_fault", 32'(fault[k]), 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        do_access(0, 1'b0, 32'h30, 32'd0, 1'b0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rdat;
        int          ri;
        n_checks = 0;
        n_err    = 0;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < DEPTH; i++) mem_m[k][i] = '0;
            rd_m[k]    = '0;
            fault_m[k] = 1'b0;
            wr[k] = 1'b0;
            addr[k] = '0;
            wd[k] = '0;
        end

        // Reset with a pending store on instance 0.
        reset = 1'b0;
        drive(0, 1'b1, 1'b1, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        check("reset_rdata", rd[0], 32'd0);
        check("reset_fault", 32'(fault[0]), 32'd0);
        check("reset_stall_idle", 32'(stall[1]), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        finish_normal(0, 1'b1, 32'h0, 32'h0);

        // Zero-fill both RAMs so the model matches regardless of power-up.
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < DEPTH; i++)
                do_access(k, 1'b1, 32'(i * 4), 32'h0, 1'b0);
        idle(1);

        // Store then load with WAIT = 2.
        do_access(0, 1'b1, 32'h10, 32'hCAFEF00D, 1'b0);
        do_access(0, 1'b0, 32'h10, 32'h0, 1'b0);
        check("load_cafe", rd_m[0], 32'hCAFEF00D);

        // WAIT = 0 back-to-back loads.
        do_access(1, 1'b1, 32'h04, 32'h11, 1'b0);
        do_access(1, 1'b1, 32'h08, 32'h22, 1'b0);
        do_access(1, 1'b0, 32'h04, 32'h0, 1'b0);
        do_access(1, 1'b0, 32'h08, 32'h0, 1'b0);
        idle(1);

        // Abort in the first BUSY cycle, then reload the untouched word.
        do_access(0, 1'b1, 32'h20, 32'hFFFFFFFF, 1'b1);
        do_access(0, 1'b0, 32'h20, 32'h0, 1'b0);

        // Address wrap-around.
        do_access(0, 1'b1, 32'h100, 32'h5A5A5A5A, 1'b0);
        do_access(0, 1'b0, 32'h000, 32'h0, 1'b0);

        // Misaligned request: rejected with the check enabled, else aligned.
        do_access(0, 1'b1, 32'h13, 32'h600DBEEF, 1'b0);
        do_access(0, 1'b0, 32'h10, 32'h0, 1'b0);
        do_access(0, 1'b1, 32'h24, 32'h12345678, 1'b0);
        idle(2);

        // Reset mid-access leaves the RAM untouched.
        reset_mid(32'hDEADBEEF);
        idle(1);

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            ri   = int'($urandom_range(0, 1));
            ra   = $urandom;
            rdat = $urandom;
            if (!ALIGN || $urandom_range(0, 7) != 0) ra[1:0] = 2'b00;
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
            if ($urandom_range(0, 39) == 0) reset_mid(rdat);
            do_access(ri, 1'($urandom_range(0, 1)), ra, rdat,
                      $urandom_range(0, 9) == 0);
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=%0d exp=%0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory controller for the 32-bit ARM-subset processor. It sits directly downstream of the datapath: it consumes `ALUResult` as the byte address and `WriteData` as store data, and returns `ReadData`. It models a word-addressed data RAM with a fixed, parameterised access latency. While an access is in flight it raises `Stall`, which freezes the PC register and the register-file write.

## Interface
- `DEPTH`, 64: number of 32-bit words. Must be a power of two, at least 4.
- `WAIT`, 2: extra wait cycles per access, range 0..15.
- `clk` input, 1: system clock. All state updates on the rising edge.
- `reset` input, 1: asynchronous, active-low reset.
- `MemEn` input, 1: this instruction accesses memory (load or store).
- `MemWrite` input, 1: 1 = store, 0 = load. Only meaningful while `MemEn` = 1.
- `ALUResult` input, 32: byte address.
- `WriteData` input, 32: store data.
- `ReadData` output, 32: load data, registered.
- `Stall` output, 1: 1 = hold the PC and suppress `RegWrite` this cycle.
- `Fault` output, 1: sticky misaligned-access flag (see Configuration).

## Operation
- State machine has three states: IDLE, BUSY, DONE.
- IDLE
  - `MemEn` = 1: capture address, data and `MemWrite`, then go to BUSY with counter = `WAIT`. If `WAIT` = 0, go straight to DONE.
  - `MemEn` = 0: stay in IDLE.
- BUSY
  - Counter decrements each cycle.
  - When the counter reaches 1, go to DONE on the next edge.
- DONE
  - Always returns to IDLE after one cycle.
  - It never re-accepts the request it just completed.
- `Stall` is combinational:
  - 1 in IDLE when `MemEn` = 1.
  - 1 throughout BUSY.
  - 0 in DONE and in idle IDLE.
- Commit point: the write into the RAM, or the `ReadData` update for a load, happens on the edge that enters DONE.
  - Captured values are used, not live inputs.
- `ReadData` holds its last load value across stores and idle cycles.
- Word index is `addr[log2(DEPTH)+1:2]`. Upper address bits are ignored, so addresses wrap modulo `DEPTH`×4.
- Abort rule: if `MemEn` drops to 0 while in BUSY, return to IDLE on the next edge.
  - No write is performed and `ReadData` is unchanged.
- RAM contents are not reset. Simulation initialises them to 0.

## Timing
- Reset values while `reset` = 0:
  - state = IDLE
  - `ReadData` = 0
  - `Fault` = 0
  - `Stall` = 0 while `MemEn` = 0
- Reset asserted mid-access aborts the access. No RAM write occurs.
- Stall duration is `WAIT`+1 cycles. A memory instruction occupies `WAIT`+2 cycles in total.
  - `WAIT` = 2: the request cycle, 2 BUSY cycles, then the DONE cycle.
- `ReadData` is valid for the whole DONE cycle. The datapath writes it back in that cycle.
- The datapath must hold `MemEn`, `MemWrite`, `ALUResult` and `WriteData` stable while `Stall` = 1. The controller uses its captured copies regardless.
- Back-to-back memory instructions: DONE → IDLE → a new request the cycle after DONE. There is no lost cycle beyond the fixed latency.

## Configuration
- Macro: `DMEM_ALIGN_CHECK_EN`.
- When defined, a request with `addr[1:0]` ≠ 0 is rejected in IDLE:
  - `Stall` stays 0.
  - The FSM does not leave IDLE.
  - No write occurs and `ReadData` is unchanged.
  - `Fault` is set on that edge and stays 1 until reset.
- When undefined:
  - `addr[1:0]` is ignored and the access proceeds to the aligned word.
  - `Fault` is tied to 0.

## Test plan
- Reset: drive `reset` = 0 with `MemEn` = 1 → `ReadData` = 0, `Fault` = 0, state IDLE. Release reset → `Stall` goes to 1 the same cycle.
- Store then load, `WAIT` = 2: store 0xCAFEF00D to 0x10. Check `Stall` = 1 for exactly 3 cycles. Then load 0x10 → `ReadData` = 0xCAFEF00D in the DONE cycle, and `Stall` = 1 for 3 cycles again.
- `WAIT` = 0 with back-to-back loads from 0x04 and 0x08, preloaded 0x11 and 0x22 → each load stalls 1 cycle, and `ReadData` shows 0x11 then 0x22 on consecutive DONE cycles.
- Abort: start a store of 0xFFFFFFFF to 0x20. Drop `MemEn` in the first BUSY cycle → FSM returns to IDLE, and a later load of 0x20 returns the old value 0.
- Wrap-around with `DEPTH` = 64: store 0x5A5A5A5A to 0x100 → load from 0x000 returns 0x5A5A5A5A.
- With `DMEM_ALIGN_CHECK_EN`: load 0x13 → `Stall` stays 0, `Fault` = 1 from the next cycle and remains 1 across a following aligned access, and `ReadData` is unchanged.
